// File: rtl/dco_code_controller.sv
// ADPLL loop controller: SAR search on the DCO coarse code, then +/-1 tracking
// with lock detection (reversal count) and loss-of-lock detection (run count).
module dco_code_controller #(
    parameter int CODE_W     = 6,
    parameter int SETTLE     = 2,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3
) (
    input  logic              phase_clk,
    input  logic              reset,
    input  logic              p_up,
    input  logic              p_down,
    output logic [CODE_W-1:0] coarse,
    output logic              freq_lock,
    output logic              polarity,
    output logic [1:0]        state_o,
    output logic              lock_lost
);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam int SET_W = $clog2(SETTLE + 2);
    localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CNT_W = $clog2(CNT_MAX + 2);
    localparam logic [CODE_W-1:0] CODE_MID  = CODE_W'(1) << (CODE_W - 1);
    localparam logic [CODE_W-1:0] STEP_INIT = CODE_W'(1) << (CODE_W - 2);

    state_t             state_q, state_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [CODE_W-1:0]  coarse_q, coarse_d;
    logic [CODE_W-1:0]  step_q, step_d;
    logic               pol_q, pol_d;
    logic               lock_q, lock_d;
    logic               lost_q, lost_d;
    logic [CNT_W-1:0]   rev_q, rev_d;
    logic [CNT_W-1:0]   run_q, run_d;

    logic               sample, dec_up, dec_dn, dec_al, dir_same, sat;
    logic [CODE_W-1:0]  step_v;
    logic [CODE_W:0]    sum, diff;

    // Decisions are taken only on the sampling edge that ends each settle window.
    assign sample = (settle_q == SET_W'(SETTLE));
    assign dec_up = p_up & ~p_down;
    assign dec_dn = p_down & ~p_up;
    assign dec_al = ~p_up & ~p_down;

    // Next code is formed one bit wider so both directions clamp instead of wrapping.
    assign step_v   = (state_q == S_SEARCH) ? step_q : CODE_W'(1);
    assign sum      = {1'b0, coarse_q} + {1'b0, step_v};
    assign diff     = {1'b0, coarse_q} - {1'b0, step_v};
    assign sat      = (dec_up & sum[CODE_W]) | (dec_dn & diff[CODE_W]);
    assign dir_same = dec_up ? pol_q : ~pol_q;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q + SET_W'(1);
        coarse_d = coarse_q;
        step_d   = step_q;
        pol_d    = pol_q;
        lock_d   = lock_q;
        lost_d   = 1'b0;
        rev_d    = rev_q;
        run_d    = run_q;

        if (sample) begin
            settle_d = '0;
            if (dec_up) begin
                coarse_d = sum[CODE_W] ? '1 : sum[CODE_W-1:0];
                pol_d    = 1'b1;
            end else if (dec_dn) begin
                coarse_d = diff[CODE_W] ? '0 : diff[CODE_W-1:0];
                pol_d    = 1'b0;
            end

            if (dec_up | dec_dn | dec_al) begin
                case (state_q)
                    S_SEARCH: begin
                        step_d = step_q >> 1;
                        if (step_d == '0) state_d = S_TRACK;
                    end
                    S_TRACK: begin
                        // Clamped requests count as same-direction, so a rail never fakes lock.
                        if (dec_al || (!dir_same && !sat)) rev_d = rev_q + CNT_W'(1);
                        else                               rev_d = '0;
                        if (rev_d == CNT_W'(LOCK_CNT)) begin
                            state_d = S_LOCKED;
                            lock_d  = 1'b1;
                            rev_d   = '0;
                            run_d   = '0;
                        end
                    end
                    S_LOCKED: begin
                        // A direction change starts a new run of length one.
                        if (dec_al)        run_d = '0;
                        else if (dir_same) run_d = run_q + CNT_W'(1);
                        else               run_d = CNT_W'(1);
                        if (run_d == CNT_W'(UNLOCK_CNT)) begin
                            state_d = S_TRACK;
                            lock_d  = 1'b0;
                            lost_d  = 1'b1;
                            rev_d   = '0;
                            run_d   = '0;
                        end
                    end
                    default: state_d = S_SEARCH;
                endcase
            end
        end
    end

    always_ff @(posedge phase_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_SEARCH;
            settle_q <= '0;
            coarse_q <= CODE_MID;
            step_q   <= STEP_INIT;
            pol_q    <= 1'b0;
            lock_q   <= 1'b0;
            lost_q   <= 1'b0;
            rev_q    <= '0;
            run_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            coarse_q <= coarse_d;
            step_q   <= step_d;
            pol_q    <= pol_d;
            lock_q   <= lock_d;
            lost_q   <= lost_d;
            rev_q    <= rev_d;
            run_q    <= run_d;
        end
    end

    assign coarse    = coarse_q;
    assign freq_lock = lock_q;
    assign polarity  = pol_q;
    assign state_o   = state_q;
    assign lock_lost = lost_q;

endmodule

// File: tb/tb_dco_code_controller.sv
// Directed bench for dco_code_controller: expected outputs are queued per clock
// by the driver and compared by an independent negedge monitor.
module tb_dco_code_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       p_up = 1'b0;
    logic       p_down = 1'b0;
    logic [5:0] coarse;
    logic       freq_lock, polarity, lock_lost;
    logic [1:0] state_o;

    dco_code_controller #(
        .CODE_W(6), .SETTLE(2), .LOCK_CNT(4), .UNLOCK_CNT(3)
    ) dut (
        .phase_clk(clk),
        .reset    (rst_n),
        .p_up     (p_up),
        .p_down   (p_down),
        .coarse   (coarse),
        .freq_lock(freq_lock),
        .polarity (polarity),
        .state_o  (state_o),
        .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    // Packed expectation: {lock_lost, state_o[1:0], polarity, freq_lock, coarse[5:0]}
    localparam int W = 11;
    localparam logic [W-1:0] RST_EXP = {1'b0, 2'd0, 1'b0, 1'b0, 6'd32};
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur;
    logic [W-1:0] mon_exp, mon_act;
    int           n_checks = 0;
    int           n_fail = 0;
    string        tag = "reset";

    // Monitor: one expectation per clock, compared away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {lock_lost, state_o, polarity, freq_lock, coarse};
            n_checks++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL %s: got lost=%0b state=%0d pol=%0b lock=%0b coarse=%0d, expected lost=%0b state=%0d pol=%0b lock=%0b coarse=%0d",
                         tag, mon_act[10], mon_act[9:8], mon_act[7], mon_act[6], mon_act[5:0],
                         mon_exp[10], mon_exp[9:8], mon_exp[7], mon_exp[6], mon_exp[5:0]);
            end
        end
    end

    task automatic check_now(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // One decision window: two idle edges (outputs hold, no pulse) then the sampling edge.
    task automatic decide(input logic u, input logic d, input logic [5:0] c, input logic lk,
                          input logic pol, input logic [1:0] st, input logic lost);
        p_up   = u;
        p_down = d;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (k < 2) begin
                exp_q.push_back({1'b0, cur[9:0]});
            end else begin
                cur = {1'b0, st, pol, lk, c};
                exp_q.push_back({lost, st, pol, lk, c});
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n  = 1'b0;
        p_up   = 1'b0;
        p_down = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cur   = RST_EXP;
    endtask

    // Search toward a target of 45 from reset.
    task automatic search_45();
        decide(1, 0, 6'd48, 0, 1, 2'd0, 0);
        decide(0, 1, 6'd40, 0, 0, 2'd0, 0);
        decide(1, 0, 6'd44, 0, 1, 2'd0, 0);
        decide(1, 0, 6'd46, 0, 1, 2'd0, 0);
        decide(0, 1, 6'd45, 0, 0, 2'd1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        cur = RST_EXP;
        // Reset held: outputs at their reset values.
        #12;
        check_now("rst_coarse", int'(coarse), 32);
        check_now("rst_lock", int'(freq_lock), 0);
        check_now("rst_pol", int'(polarity), 0);
        check_now("rst_state", int'(state_o), 0);
        check_now("rst_lost", int'(lock_lost), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Asynchronous reset mid-search takes effect with no clock edge.
        tag = "mid_search";
        decide(1, 0, 6'd48, 0, 1, 2'd0, 0);
        decide(1, 0, 6'd56, 0, 1, 2'd0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_now("async_rst_coarse", int'(coarse), 32);
        check_now("async_rst_pol", int'(polarity), 0);
        check_now("async_rst_state", int'(state_o), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cur   = RST_EXP;

        // Constant up: search climbs to the top rail, TRACK holds it without locking.
        tag = "up_saturate";
        decide(1, 0, 6'd48, 0, 1, 2'd0, 0);
        decide(1, 0, 6'd56, 0, 1, 2'd0, 0);
        decide(1, 0, 6'd60, 0, 1, 2'd0, 0);
        decide(1, 0, 6'd62, 0, 1, 2'd0, 0);
        decide(1, 0, 6'd63, 0, 1, 2'd1, 0);
        for (int i = 0; i < 5; i++) decide(1, 0, 6'd63, 0, 1, 2'd1, 0);

        // Target 45: search then four aligned decisions declare lock.
        do_reset();
        tag = "lock_45";
        search_45();
        decide(0, 0, 6'd45, 0, 0, 2'd1, 0);
        decide(0, 0, 6'd45, 0, 0, 2'd1, 0);
        decide(0, 0, 6'd45, 0, 0, 2'd1, 0);
        decide(0, 0, 6'd45, 1, 0, 2'd2, 0);

        // Target moves to 50: three ups lose lock at 48, then track and relock at 50.
        tag = "unlock_50";
        decide(1, 0, 6'd46, 1, 1, 2'd2, 0);
        decide(1, 0, 6'd47, 1, 1, 2'd2, 0);
        decide(1, 0, 6'd48, 0, 1, 2'd1, 1);
        tag = "relock_50";
        decide(1, 0, 6'd49, 0, 1, 2'd1, 0);
        decide(1, 0, 6'd50, 0, 1, 2'd1, 0);
        decide(0, 0, 6'd50, 0, 1, 2'd1, 0);
        decide(0, 0, 6'd50, 0, 1, 2'd1, 0);
        decide(0, 0, 6'd50, 0, 1, 2'd1, 0);
        decide(0, 0, 6'd50, 1, 1, 2'd2, 0);

        // Both PFD outputs high in TRACK: everything holds, including the reversal count.
        do_reset();
        tag = "both_high";
        search_45();
        decide(0, 0, 6'd45, 0, 0, 2'd1, 0);
        decide(0, 0, 6'd45, 0, 0, 2'd1, 0);
        for (int i = 0; i < 5; i++) decide(1, 1, 6'd45, 0, 0, 2'd1, 0);
        decide(0, 0, 6'd45, 0, 0, 2'd1, 0);
        decide(0, 0, 6'd45, 1, 0, 2'd2, 0);

        // Target 1: down search, bottom rail clamps at 0, alternating decisions lock.
        do_reset();
        tag = "down_rail";
        decide(0, 1, 6'd16, 0, 0, 2'd0, 0);
        decide(0, 1, 6'd8,  0, 0, 2'd0, 0);
        decide(0, 1, 6'd4,  0, 0, 2'd0, 0);
        decide(0, 1, 6'd2,  0, 0, 2'd0, 0);
        decide(0, 1, 6'd1,  0, 0, 2'd1, 0);
        decide(0, 1, 6'd0,  0, 0, 2'd1, 0);
        decide(0, 1, 6'd0,  0, 0, 2'd1, 0);
        decide(1, 0, 6'd1,  0, 1, 2'd1, 0);
        decide(0, 1, 6'd0,  0, 0, 2'd1, 0);
        decide(1, 0, 6'd1,  0, 1, 2'd1, 0);
        decide(0, 1, 6'd0,  1, 0, 2'd2, 0);
        decide(1, 0, 6'd1,  1, 1, 2'd2, 0);

        p_up   = 1'b0;
        p_down = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_now("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
